rv32imf_ext_irq_arbiter: RTL and testbench

//  PLIC-style external interrupt arbiter ahead of the core interrupt controller.
//  - Collects NUM_SRC external sources and applies per-source level/edge gateways, priority and enable.
//  - Drives the single machine-external interrupt line, core irq_i[11] (MEI).
//  - Software claims the winning source ID through a register port and signals completion through the same port.

---
 rtl/rv32imf_ext_irq_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_rv32imf_ext_irq_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32imf_ext_irq_arbiter.sv
// ----------------------------------------------------------------------------
// rv32imf_ext_irq_arbiter
//
// External interrupt arbiter that sits in front of the core interrupt
// controller. It collects NUM_SRC external sources, passes each through a
// level or rising-edge gateway, and picks the highest-priority enabled pending
// source. The result drives the machine-external interrupt line (MEI).
// Software claims the winning ID by reading CLAIM and completes it by writing
// the ID back to CLAIM.
//
// Source n (src_i[n]) has ID n+1. ID 0 means "no source".
//
// Ports
//   clk           clock
//   rst_n         asynchronous active-low reset
//   src_i         raw asynchronous interrupt sources
//   reg_req_i     register access request (always accepted)
//   reg_we_i      1 = write, 0 = read
//   reg_addr_i    byte address, bits [1:0] ignored
//   reg_wdata_i   write data
//   reg_rdata_o   read data, valid while reg_rvalid_o is high
//   reg_rvalid_o  high exactly one cycle after each read request
//   meip_o        machine external interrupt request to the core
//
// Register map (byte offsets)
//   0x00 + 4*ID  PRIO[ID]   RW, ID 1..NUM_SRC (others read 0, writes ignored)
//   0x80         PENDING    RO, bit ID
//   0x84         ENABLE     RW, bit ID, bit 0 always 0
//   0x88         EDGE       RW, bit ID: 1 = rising edge, 0 = level
//   0x8C         THRESHOLD  RW
//   0x90         CLAIM      read = claim, write = complete
// ----------------------------------------------------------------------------
module rv32imf_ext_irq_arbiter #(
    parameter int NUM_SRC = 16,
    parameter int PRIO_W  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               reg_req_i,
    input  logic               reg_we_i,
    input  logic [7:0]         reg_addr_i,
    input  logic [31:0]        reg_wdata_i,
    output logic [31:0]        reg_rdata_o,
    output logic               reg_rvalid_o,
    output logic               meip_o
);

    // Bits [NUM_SRC:1] of every ID-indexed vector are real; the rest stay 0.
    localparam logic [31:0] SRC_MASK = ((32'd1 << NUM_SRC) - 32'd1) << 1;

    localparam logic [5:0] W_PENDING = 6'd32;
    localparam logic [5:0] W_ENABLE  = 6'd33;
    localparam logic [5:0] W_EDGE    = 6'd34;
    localparam logic [5:0] W_THRESH  = 6'd35;
    localparam logic [5:0] W_CLAIM   = 6'd36;

    // Synchronizer and edge-detect history
    logic [NUM_SRC-1:0] s_meta, s_q, s_q_prev;

    // Configuration
    logic [PRIO_W-1:0]  prio_q [1:NUM_SRC];
    logic [31:0]        enable_q, edge_q;
    logic [PRIO_W-1:0]  threshold_q;

    // Gateway / claim state, all indexed by ID
    logic [31:0]        pending_q, inflight_q, edge_hold_q;

    // Arbitration result
    logic [4:0]         best_id_q;
    logic [4:0]         best_id_c;
    logic [PRIO_W-1:0]  best_prio_c;

    // Register port
    logic [5:0]         word;
    logic               wr_fire, rd_fire, claim_fire, complete_fire;
    logic [31:0]        rdata_next;

    // Gateway next-state terms
    logic [31:0] s_vec, edge_vec, level_set, edge_set, blocked;
    logic [31:0] hold_release, set_mask, claim_mask, complete_mask;
    logic [31:0] pending_next, inflight_next, edge_hold_next;

    assign word          = 6'(reg_addr_i >> 2);
    assign wr_fire       = reg_req_i &&  reg_we_i;
    assign rd_fire       = reg_req_i && !reg_we_i;
    assign claim_fire    = rd_fire && (word == W_CLAIM);
    assign complete_fire = wr_fire && (word == W_CLAIM);

    assign s_vec    = 32'({s_q, 1'b0});
    assign edge_vec = 32'({s_q & ~s_q_prev, 1'b0});

    // A claim of ID 0 is a no-op, so it produces an empty mask.
    assign claim_mask    = (claim_fire && best_id_q != 5'd0) ? (32'd1 << best_id_q) : 32'd0;
    // Only an ID that is actually in flight can be completed; everything else
    // (ID 0, out-of-range IDs, not-in-flight IDs) masks to nothing.
    assign complete_mask = complete_fire ? ((32'd1 << reg_wdata_i[4:0]) & inflight_q & SRC_MASK)
                                         : 32'd0;

    // The ID being claimed this cycle is treated as already in flight, so an
    // edge arriving in the claim cycle lands in edge_hold instead of being
    // set-then-cleared and lost.
    assign blocked        = inflight_q | claim_mask;
    assign level_set      = s_vec & ~edge_q;
    assign edge_set       = edge_vec & edge_q;
    assign hold_release   = edge_hold_q & ~blocked;
    assign set_mask       = (level_set | edge_set | hold_release) & ~blocked & SRC_MASK;
    assign pending_next   = (pending_q | set_mask) & ~claim_mask;
    assign edge_hold_next = ((edge_hold_q & ~hold_release) | (edge_set & blocked)) & SRC_MASK;
    assign inflight_next  = (inflight_q & ~complete_mask) | claim_mask;

    // Strict '>' while scanning upward keeps the lowest ID on a tie; starting
    // from priority 0 excludes priority-0 sources automatically.
    always_comb begin
        best_id_c   = 5'd0;
        best_prio_c = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            if (pending_q[i] && enable_q[i] && (prio_q[i] > best_prio_c)) begin
                best_prio_c = prio_q[i];
                best_id_c   = 5'(i);
            end
        end
    end

    // Reads observe the current (pre-update) register values.
    always_comb begin
        rdata_next = 32'd0;
        case (word)
            W_PENDING: rdata_next = pending_q;
            W_ENABLE:  rdata_next = enable_q;
            W_EDGE:    rdata_next = edge_q;
            W_THRESH:  rdata_next = 32'(threshold_q);
            W_CLAIM:   rdata_next = 32'(best_id_q);
            default: begin
                for (int i = 1; i <= NUM_SRC; i++) begin
                    if (word == 6'(i)) rdata_next = 32'(prio_q[i]);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_meta       <= '0;
            s_q          <= '0;
            s_q_prev     <= '0;
            for (int i = 1; i <= NUM_SRC; i++) prio_q[i] <= '0;
            enable_q     <= 32'd0;
            edge_q       <= 32'd0;
            threshold_q  <= '0;
            pending_q    <= 32'd0;
            inflight_q   <= 32'd0;
            edge_hold_q  <= 32'd0;
            best_id_q    <= 5'd0;
            meip_o       <= 1'b0;
            reg_rdata_o  <= 32'd0;
            reg_rvalid_o <= 1'b0;
        end else begin
            s_meta      <= src_i;
            s_q         <= s_meta;
            s_q_prev    <= s_q;

            pending_q   <= pending_next;
            inflight_q  <= inflight_next;
            edge_hold_q <= edge_hold_next;

            best_id_q   <= best_id_c;
            // Registered alongside best_id_q so MEI and CLAIM always agree.
            meip_o      <= (best_prio_c > threshold_q);

            reg_rvalid_o <= rd_fire;
            if (rd_fire) reg_rdata_o <= rdata_next;

            if (wr_fire) begin
                case (word)
                    W_ENABLE: enable_q    <= reg_wdata_i & SRC_MASK;
                    W_EDGE:   edge_q      <= reg_wdata_i & SRC_MASK;
                    W_THRESH: threshold_q <= reg_wdata_i[PRIO_W-1:0];
                    default: begin
                        for (int i = 1; i <= NUM_SRC; i++) begin
                            if (word == 6'(i)) prio_q[i] <= reg_wdata_i[PRIO_W-1:0];
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rv32imf_ext_irq_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rv32imf_ext_irq_arbiter
//
// Directed test of the external interrupt arbiter: level and edge gateways,
// priority/tie arbitration, threshold, claim/complete, bogus completes,
// address boundaries, reset in the middle of a claim, and an edge arriving
// in the same cycle as its own claim.
// ----------------------------------------------------------------------------
module tb_rv32imf_ext_irq_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] src;
    logic        req, we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        meip;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [7:0] A_PENDING = 8'h80;
    localparam logic [7:0] A_ENABLE  = 8'h84;
    localparam logic [7:0] A_EDGE    = 8'h88;
    localparam logic [7:0] A_THRESH  = 8'h8C;
    localparam logic [7:0] A_CLAIM   = 8'h90;

    rv32imf_ext_irq_arbiter #(.NUM_SRC(16), .PRIO_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_i       (src),
        .reg_req_i   (req),
        .reg_we_i    (we),
        .reg_addr_i  (addr),
        .reg_wdata_i (wdata),
        .reg_rdata_o (rdata),
        .reg_rvalid_o(rvalid),
        .meip_o      (meip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        $display("WR  addr=0x%02h data=0x%08h", a, d);
    endtask

    task automatic reg_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = a;
        @(posedge clk); #1;
        req = 1'b0;
        chk("rvalid_pulse", {31'b0, rvalid}, 32'd1);
        d = rdata;
        $display("RD  addr=0x%02h data=0x%08h", a, d);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        reg_read(a, d);
        chk(tag, d, exp);
    endtask

    // Bounded wait for meip to reach a value; an expired bound is a failure.
    task automatic wait_meip(input string tag, input logic exp, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk); #1;
            if (meip === exp) break;
        end
        chk(tag, {31'b0, meip}, {31'b0, exp});
    endtask

    // meip must stay low on every sampled cycle of the window.
    task automatic hold_meip_low(input string tag, input int cycles);
        int highs;
        highs = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (meip !== 1'b0) highs++;
        end
        chk(tag, 32'(highs), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; src = '0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_meip",   {31'b0, meip},   32'd0);
        chk("reset_rvalid", {31'b0, rvalid}, 32'd0);
        chk("reset_rdata",  rdata,           32'd0);
        @(negedge clk); rst_n = 1'b1;
        rd_chk("reset_pending", A_PENDING, 32'd0);
        rd_chk("reset_enable",  A_ENABLE,  32'd0);

        // ---- 1. Level source ID 3 -------------------------------------------
        reg_write(8'h0C, 32'd2);
        reg_write(A_ENABLE, 32'h8);
        reg_write(A_THRESH, 32'd0);
        @(negedge clk); src[2] = 1'b1;
        wait_meip("lvl_meip_rise", 1'b1, 4);
        rd_chk("lvl_pending", A_PENDING, 32'h8);
        rd_chk("lvl_claim", A_CLAIM, 32'd3);
        @(posedge clk); #1;
        chk("lvl_meip_after_claim", {31'b0, meip}, 32'd0);
        rd_chk("lvl_pending_inflight", A_PENDING, 32'h0);
        reg_write(A_CLAIM, 32'd3);
        wait_meip("lvl_repend_meip", 1'b1, 4);
        rd_chk("lvl_reclaim", A_CLAIM, 32'd3);
        src[2] = 1'b0;
        repeat (4) @(negedge clk);
        reg_write(A_CLAIM, 32'd3);
        hold_meip_low("lvl_low_no_repend", 6);
        rd_chk("lvl_pending_idle", A_PENDING, 32'h0);

        // ---- 2. Priority and tie: IDs 2,5,6 at PRIO 1,4,4 --------------------
        reg_write(8'h08, 32'd1);
        reg_write(8'h14, 32'd4);
        reg_write(8'h18, 32'd4);
        reg_write(A_ENABLE, 32'h64);
        @(negedge clk); src = 16'h0032;
        repeat (3) @(negedge clk);
        src = '0;
        repeat (3) @(negedge clk);
        rd_chk("prio_pending", A_PENDING, 32'h64);
        chk("prio_meip", {31'b0, meip}, 32'd1);
        rd_chk("prio_claim_1st", A_CLAIM, 32'd5);
        reg_write(A_CLAIM, 32'd5);
        rd_chk("prio_claim_2nd", A_CLAIM, 32'd6);
        reg_write(A_CLAIM, 32'd6);
        rd_chk("prio_claim_3rd", A_CLAIM, 32'd2);
        reg_write(A_CLAIM, 32'd2);
        // Threshold equal to the top priority masks MEI but not CLAIM.
        reg_write(A_THRESH, 32'd4);
        @(negedge clk); src = 16'h0032;
        hold_meip_low("thr_blocks_meip", 8);
        src = '0;
        repeat (4) @(negedge clk);
        rd_chk("thr_pending", A_PENDING, 32'h64);
        rd_chk("thr_claim_1st", A_CLAIM, 32'd5);
        reg_write(A_CLAIM, 32'd5);
        rd_chk("thr_claim_2nd", A_CLAIM, 32'd6);
        reg_write(A_CLAIM, 32'd6);
        rd_chk("thr_claim_3rd", A_CLAIM, 32'd2);
        reg_write(A_CLAIM, 32'd2);
        reg_write(A_THRESH, 32'd0);

        // ---- 3. Edge source ID 4 --------------------------------------------
        reg_write(8'h10, 32'd3);
        reg_write(A_EDGE, 32'h10);
        reg_write(A_ENABLE, 32'h10);
        @(negedge clk); src[3] = 1'b1;
        repeat (2) @(negedge clk);
        src[3] = 1'b0;
        wait_meip("edge_meip_rise", 1'b1, 4);
        rd_chk("edge_claim", A_CLAIM, 32'd4);
        @(negedge clk); src[3] = 1'b1;
        repeat (2) @(negedge clk);
        src[3] = 1'b0;
        hold_meip_low("edge_held_no_meip", 6);
        rd_chk("edge_held_pending", A_PENDING, 32'h0);
        reg_write(A_CLAIM, 32'd4);
        wait_meip("edge_hold_repend", 1'b1, 4);
        rd_chk("edge_reclaim", A_CLAIM, 32'd4);
        reg_write(A_CLAIM, 32'd4);
        hold_meip_low("edge_single_repend", 6);

        // ---- 4. Bogus completes and address boundaries ----------------------
        reg_write(A_CLAIM, 32'd7);
        reg_write(A_CLAIM, 32'd0);
        rd_chk("bogus_pending", A_PENDING, 32'h0);
        rd_chk("bogus_enable", A_ENABLE, 32'h10);
        chk("bogus_meip", {31'b0, meip}, 32'd0);
        reg_write(8'h00, 32'd7);
        rd_chk("prio0_reads_zero", 8'h00, 32'd0);
        rd_chk("prio17_reads_zero", 8'h44, 32'd0);
        rd_chk("unmapped_reads_zero", 8'hA0, 32'd0);
        rd_chk("prio4_readback", 8'h10, 32'd3);
        reg_write(A_ENABLE, 32'hFFFF_FFFF);
        rd_chk("enable_mask", A_ENABLE, 32'h0001_FFFE);
        rd_chk("empty_claim", A_CLAIM, 32'd0);
        @(posedge clk); #1;
        chk("rvalid_one_cycle", {31'b0, rvalid}, 32'd0);

        // ---- 5. Reset with ID 2 in flight and ID 3 pending -------------------
        reg_write(A_ENABLE, 32'h0C);
        @(negedge clk); src[1] = 1'b1;
        wait_meip("rst_setup_meip", 1'b1, 4);
        rd_chk("rst_setup_claim", A_CLAIM, 32'd2);
        @(negedge clk); src[2] = 1'b1;
        wait_meip("rst_id3_meip", 1'b1, 6);
        @(negedge clk); rst_n = 1'b0; src = '0;
        #1;
        chk("rst_async_meip",  {31'b0, meip}, 32'd0);
        chk("rst_async_rdata", rdata,         32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_chk("rst_pending", A_PENDING, 32'h0);
        rd_chk("rst_enable",  A_ENABLE,  32'h0);
        rd_chk("rst_edge",    A_EDGE,    32'h0);
        rd_chk("rst_thresh",  A_THRESH,  32'h0);
        rd_chk("rst_prio3",   8'h0C,     32'h0);
        rd_chk("rst_claim",   A_CLAIM,   32'h0);
        hold_meip_low("rst_meip_stays_low", 4);

        // ---- 6. Edge on ID 1 in its own claim cycle --------------------------
        reg_write(A_EDGE, 32'h2);
        reg_write(8'h04, 32'd2);
        reg_write(A_ENABLE, 32'h2);
        @(negedge clk); src[0] = 1'b1;
        repeat (2) @(negedge clk);
        src[0] = 1'b0;
        wait_meip("same_setup_meip", 1'b1, 4);
        repeat (3) @(negedge clk);
        // Rise here; the edge is detected two cycles later, which is exactly
        // the cycle the claim below is sampled.
        src[0] = 1'b1;
        @(negedge clk);
        rd_chk("same_claim", A_CLAIM, 32'd1);
        src[0] = 1'b0;
        hold_meip_low("same_edge_held", 5);
        rd_chk("same_pending_held", A_PENDING, 32'h0);
        reg_write(A_CLAIM, 32'd1);
        wait_meip("same_repend_meip", 1'b1, 4);
        rd_chk("same_reclaim", A_CLAIM, 32'd1);
        reg_write(A_CLAIM, 32'd1);
        hold_meip_low("same_final_idle", 4);
        rd_chk("same_final_pending", A_PENDING, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
